// File: rtl/ps2_key_event_decoder.sv
// rtl/ps2_key_event_decoder.sv - PS/2 scan byte to key event decoder with event FIFO
//
// Pops raw scan bytes from ps2_keyboard through the ready/nextdata_n handshake.
// Folds E0 (extended) and F0 (break) prefixes into single key events. Tracks the
// held key, counts presses and queues events in a show-ahead FIFO.
//
// Optional build macro: PS2_TYPEMATIC_EN
//   defined   - typematic repeats are queued with evt_repeat=1
//   undefined - typematic repeats are discarded, evt_repeat stays 0
//
// Ports:
//   clk, clrn         clock, asynchronous active-low reset
//   kb_data/kb_ready  scan byte and byte-available from ps2_keyboard
//   kb_overflow       ps2_keyboard overflow flag
//   kb_nextdata_n     one-cycle active-low pop strobe to ps2_keyboard
//   evt_valid/ready   FIFO head handshake (pop on valid & ready)
//   evt_code/ext/break/repeat  head event fields
//   key_down, cur_code         held-key state, cur_code = {ext, code}
//   press_cnt         non-repeat make count, wraps
//   fifo_ovf, kb_ovf  sticky overflow flags
//   err               one-cycle pulse on an illegal byte (00 or FF)
module ps2_key_event_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic             key_down,
  output logic [8:0]       cur_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             fifo_ovf,
  output logic             kb_ovf,
  output logic             err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]  state;
  logic [7:0]  byte_q;
  logic        pend_ext;
  logic        pend_brk;

  // Entry layout: {ext, break, repeat, code}
  logic [10:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        is_pop, is_e0, is_f0, is_bad, is_evt;
  logic [8:0]  evt_key;
  logic        key_match, is_make, is_rpt, is_new, is_brk;
  logic        push_req, rpt_bit;
  logic [10:0] push_data;
  logic        do_pop, do_push, fifo_full;
  logic [AW:0] rd_nxt, wr_nxt;
  logic [10:0] head_nxt;

  always_comb begin
    is_pop    = (state == ST_POP);
    is_e0     = (byte_q == 8'hE0);
    is_f0     = (byte_q == 8'hF0);
    is_bad    = (byte_q == 8'h00) || (byte_q == 8'hFF);
    is_evt    = is_pop && !is_e0 && !is_f0 && !is_bad;
    evt_key   = {pend_ext, byte_q};
    key_match = (evt_key == cur_code);
    is_make   = is_evt && !pend_brk;
    // A make of the key already held is the keyboard's typematic repeat
    is_rpt    = is_make && key_down && key_match;
    is_new    = is_make && !is_rpt;
    is_brk    = is_evt && pend_brk;
`ifdef PS2_TYPEMATIC_EN
    push_req  = is_evt;
    rpt_bit   = is_rpt;
`else
    push_req  = is_evt && !is_rpt;
    rpt_bit   = 1'b0;
`endif
    push_data = {pend_ext, pend_brk, rpt_bit, byte_q};

    do_pop    = evt_valid && evt_ready;
    fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a push on full still lands
    do_push   = push_req && (!fifo_full || do_pop);
    rd_nxt    = rd_ptr + {{AW{1'b0}}, do_pop};
    wr_nxt    = wr_ptr + {{AW{1'b0}}, do_push};
    // Next head is the entry being written this cycle when it lands in the head slot
    head_nxt  = (do_push && (rd_nxt == wr_ptr)) ? push_data : mem[rd_nxt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state         <= ST_IDLE;
      byte_q        <= 8'h00;
      pend_ext      <= 1'b0;
      pend_brk      <= 1'b0;
      kb_nextdata_n <= 1'b1;
      err           <= 1'b0;
      key_down      <= 1'b0;
      cur_code      <= 9'h000;
      press_cnt     <= '0;
      fifo_ovf      <= 1'b0;
      kb_ovf        <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      evt_valid     <= 1'b0;
      evt_ext       <= 1'b0;
      evt_break     <= 1'b0;
      evt_repeat    <= 1'b0;
      evt_code      <= 8'h00;
    end else begin
      kb_nextdata_n <= 1'b1;
      err           <= 1'b0;

      case (state)
        ST_IDLE: if (kb_ready) begin
          byte_q        <= kb_data;
          state         <= ST_POP;
          kb_nextdata_n <= 1'b0;
        end
        ST_POP:  state <= ST_WAIT;
        ST_WAIT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (is_pop) begin
        if (is_e0) begin
          pend_ext <= 1'b1;
        end else if (is_f0) begin
          pend_brk <= 1'b1;
        end else begin
          pend_ext <= 1'b0;
          pend_brk <= 1'b0;
        end
        err <= is_bad;
      end

      if (is_new) begin
        key_down  <= 1'b1;
        cur_code  <= evt_key;
        press_cnt <= press_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (is_brk && key_match) key_down <= 1'b0;

      kb_ovf <= kb_ovf | kb_overflow;
      if (push_req && !do_push) fifo_ovf <= 1'b1;

      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      evt_valid <= (rd_nxt != wr_nxt);
      // Head fields only move when something is left; they hold when empty
      if (rd_nxt != wr_nxt) {evt_ext, evt_break, evt_repeat, evt_code} <= head_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb/tb_ps2_key_event_decoder.sv - self-checking bench for ps2_key_event_decoder
module tb_ps2_key_event_decoder;

`ifdef PS2_TYPEMATIC_EN
  localparam bit TYP = 1'b1;
`else
  localparam bit TYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] kb_data;
  logic       kb_ready, kb_overflow, kb_nextdata_n;
  logic       evt_valid, evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_repeat, key_down;
  logic [8:0] cur_code;
  logic [3:0] press_cnt;
  logic       fifo_ovf, kb_ovf, err;

  always #5 clk = ~clk;

  ps2_key_event_decoder #(.FIFO_DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .evt_repeat(evt_repeat),
    .key_down(key_down), .cur_code(cur_code), .press_cnt(press_cnt),
    .fifo_ovf(fifo_ovf), .kb_ovf(kb_ovf), .err(err)
  );

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  logic [10:0] got[$];

  // Consumer side: record every accepted event and every err pulse
  always @(negedge clk) begin
    if (clrn && evt_valid && evt_ready)
      got.push_back({evt_ext, evt_break, evt_repeat, evt_code});
    if (err) err_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] ev(input bit ext, input bit brk, input bit rpt, input logic [7:0] c);
    return {ext, brk, rpt, c};
  endfunction

  // One byte through the handshake; optionally accept the head during the push cycle
  task automatic send(input logic [7:0] b, input bit pop_at_push);
    @(posedge clk); #1;
    kb_data = b; kb_ready = 1'b1;
    @(posedge clk); #1;
    if (pop_at_push) evt_ready = 1'b1;
    @(negedge clk);
    chk("nextdata_low", {31'd0, kb_nextdata_n}, 32'd0);
    @(posedge clk); #1;
    kb_ready = 1'b0;
    if (pop_at_push) evt_ready = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  b;
    bit          has;
    logic [10:0] evt;
    bit          kd;
    logic [8:0]  cur;
    logic [3:0]  cnt;
    int          nerr;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b, input bit has, input logic [10:0] e,
                              input bit kd, input logic [8:0] cur, input logic [3:0] cnt, input int nerr);
    vec_t v;
    v.b = b; v.has = has; v.evt = e; v.kd = kd; v.cur = cur; v.cnt = cnt; v.nerr = nerr;
    return v;
  endfunction

  // Reference model state for the random phase
  bit          m_held, m_pe, m_pb;
  logic [8:0]  m_cur;
  int          m_cnt, m_errs;
  logic [10:0] exp_q[$];

  task automatic model(input logic [7:0] b);
    logic [8:0] key;
    if (b == 8'hE0) m_pe = 1'b1;
    else if (b == 8'hF0) m_pb = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_errs++; m_pe = 1'b0; m_pb = 1'b0;
    end else begin
      key = {m_pe, b};
      if (!m_pb) begin
        if (m_held && key == m_cur) begin
          if (TYP) exp_q.push_back(ev(m_pe, 1'b0, 1'b1, b));
        end else begin
          m_held = 1'b1; m_cur = key; m_cnt++;
          exp_q.push_back(ev(m_pe, 1'b0, 1'b0, b));
        end
      end else begin
        exp_q.push_back(ev(m_pe, 1'b1, 1'b0, b));
        if (key == m_cur) m_held = 1'b0;
      end
      m_pe = 1'b0; m_pb = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[16];
    int n0, e0;
    logic [7:0] pool[8];
    logic [7:0] b;

    vecs[0]  = mk(8'h1C, 1,   ev(0,0,0,8'h1C), 1, 9'h01C, 4'd1, 0);
    vecs[1]  = mk(8'hF0, 0,   11'h0,           1, 9'h01C, 4'd1, 0);
    vecs[2]  = mk(8'h1C, 1,   ev(0,1,0,8'h1C), 0, 9'h01C, 4'd1, 0);
    vecs[3]  = mk(8'hE0, 0,   11'h0,           0, 9'h01C, 4'd1, 0);
    vecs[4]  = mk(8'h75, 1,   ev(1,0,0,8'h75), 1, 9'h175, 4'd2, 0);
    vecs[5]  = mk(8'hE0, 0,   11'h0,           1, 9'h175, 4'd2, 0);
    vecs[6]  = mk(8'hF0, 0,   11'h0,           1, 9'h175, 4'd2, 0);
    vecs[7]  = mk(8'h75, 1,   ev(1,1,0,8'h75), 0, 9'h175, 4'd2, 0);
    vecs[8]  = mk(8'h1B, 1,   ev(0,0,0,8'h1B), 1, 9'h01B, 4'd3, 0);
    vecs[9]  = mk(8'h1B, TYP, ev(0,0,1,8'h1B), 1, 9'h01B, 4'd3, 0);
    vecs[10] = mk(8'h1B, TYP, ev(0,0,1,8'h1B), 1, 9'h01B, 4'd3, 0);
    vecs[11] = mk(8'hF0, 0,   11'h0,           1, 9'h01B, 4'd3, 0);
    vecs[12] = mk(8'h1B, 1,   ev(0,1,0,8'h1B), 0, 9'h01B, 4'd3, 0);
    vecs[13] = mk(8'hE0, 0,   11'h0,           0, 9'h01B, 4'd3, 0);
    vecs[14] = mk(8'hFF, 0,   11'h0,           0, 9'h01B, 4'd3, 1);
    vecs[15] = mk(8'h75, 1,   ev(0,0,0,8'h75), 1, 9'h075, 4'd4, 0);

    clrn = 1'b0; kb_data = 8'h00; kb_ready = 1'b0; kb_overflow = 1'b0; evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_nextdata", {31'd0, kb_nextdata_n}, 32'd1);
    chk("rst_valid",    {31'd0, evt_valid}, 32'd0);
    chk("rst_evt",      {21'd0, evt_ext, evt_break, evt_repeat, evt_code}, 32'd0);
    chk("rst_keystate", {19'd0, key_down, cur_code, press_cnt}, 32'd0);
    chk("rst_flags",    {29'd0, fifo_ovf, kb_ovf, err}, 32'd0);
    @(posedge clk); #1;
    clrn = 1'b1;

    // Table: test-plan byte streams, one row per byte
    for (int i = 0; i < 16; i++) begin
      n0 = got.size(); e0 = err_cnt;
      send(vecs[i].b, 1'b0);
      settle();
      chk($sformatf("vec%0d_nevt", i), got.size() - n0, vecs[i].has);
      if (vecs[i].has && got.size() > n0)
        chk($sformatf("vec%0d_evt", i), {21'd0, got[$]}, {21'd0, vecs[i].evt});
      chk($sformatf("vec%0d_keydown", i), {31'd0, key_down}, {31'd0, vecs[i].kd});
      chk($sformatf("vec%0d_cur", i), {23'd0, cur_code}, {23'd0, vecs[i].cur});
      chk($sformatf("vec%0d_cnt", i), {28'd0, press_cnt}, {28'd0, vecs[i].cnt});
      chk($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].nerr);
    end

    // FIFO fill, push+pop on full, then overflow and drain
    @(posedge clk); #1;
    evt_ready = 1'b0;
    n0 = got.size();
    send(8'h15, 0); send(8'h16, 0); send(8'h1D, 0); send(8'h24, 0);
    settle();
    chk("fill_valid", {31'd0, evt_valid}, 32'd1);
    chk("fill_head", {24'd0, evt_code}, 32'h15);
    send(8'h2D, 1'b1);
    settle();
    chk("fullpop_n", got.size() - n0, 1);
    if (got.size() > n0) chk("fullpop_evt", {21'd0, got[n0]}, {21'd0, ev(0,0,0,8'h15)});
    chk("fullpop_noovf", {31'd0, fifo_ovf}, 32'd0);
    send(8'h2C, 0); send(8'h3C, 0);
    settle();
    chk("ovf_set", {31'd0, fifo_ovf}, 32'd1);
    chk("ovf_head", {24'd0, evt_code}, 32'h16);
    chk("ovf_cnt", {28'd0, press_cnt}, 32'd11);
    @(posedge clk); #1;
    evt_ready = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("drain_n", got.size() - n0, 5);
    if (got.size() >= n0 + 5) begin
      chk("drain0", {21'd0, got[n0+1]}, {21'd0, ev(0,0,0,8'h16)});
      chk("drain1", {21'd0, got[n0+2]}, {21'd0, ev(0,0,0,8'h1D)});
      chk("drain2", {21'd0, got[n0+3]}, {21'd0, ev(0,0,0,8'h24)});
      chk("drain3", {21'd0, got[n0+4]}, {21'd0, ev(0,0,0,8'h2D)});
    end
    chk("drain_valid", {31'd0, evt_valid}, 32'd0);
    chk("drain_hold", {24'd0, evt_code}, 32'h2D);
    chk("ovf_sticky", {31'd0, fifo_ovf}, 32'd1);

    // kb_overflow single-cycle pulse is captured and held
    chk("kbovf_clear", {31'd0, kb_ovf}, 32'd0);
    @(posedge clk); #1; kb_overflow = 1'b1;
    @(posedge clk); #1; kb_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("kbovf_sticky", {31'd0, kb_ovf}, 32'd1);

    // Reset in the middle of an E0 F0 prefix
    send(8'hE0, 0); send(8'hF0, 0);
    @(posedge clk); #1; clrn = 1'b0;
    @(negedge clk);
    chk("mrst_nextdata", {31'd0, kb_nextdata_n}, 32'd1);
    chk("mrst_valid",    {31'd0, evt_valid}, 32'd0);
    chk("mrst_evt",      {21'd0, evt_ext, evt_break, evt_repeat, evt_code}, 32'd0);
    chk("mrst_keystate", {19'd0, key_down, cur_code, press_cnt}, 32'd0);
    chk("mrst_flags",    {29'd0, fifo_ovf, kb_ovf, err}, 32'd0);
    @(posedge clk); #1; clrn = 1'b1;
    n0 = got.size();
    send(8'h2A, 0);
    settle();
    chk("mrst_n", got.size() - n0, 1);
    if (got.size() > n0) chk("mrst_evt2A", {21'd0, got[$]}, {21'd0, ev(0,0,0,8'h2A)});
    chk("mrst_cnt", {28'd0, press_cnt}, 32'd1);

    // Random byte stream against the reference model
    @(posedge clk); #1; clrn = 1'b0;
    @(posedge clk); #1;
    got.delete();
    e0 = err_cnt;
    clrn = 1'b1;
    m_held = 0; m_pe = 0; m_pb = 0; m_cur = 9'h0; m_cnt = 0; m_errs = 0;
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1C; pool[3] = 8'h1B;
    pool[4] = 8'h75; pool[5] = 8'h2A; pool[6] = 8'h00; pool[7] = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 7)];
      model(b);
      send(b, 1'b0);
    end
    repeat (6) @(negedge clk);
    #1;
    chk("rnd_nevt", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("rnd_evt%0d", i), {21'd0, got[i]}, {21'd0, exp_q[i]});
    chk("rnd_keydown", {31'd0, key_down}, {31'd0, m_held});
    chk("rnd_cur", {23'd0, cur_code}, {23'd0, m_cur});
    chk("rnd_cnt", {28'd0, press_cnt}, m_cnt % 16);
    chk("rnd_err", err_cnt - e0, m_errs);
    chk("rnd_noovf", {31'd0, fifo_ovf}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
